// File: rtl/dm_cache_pkg.sv
// Shared address-slicing constants and types for the direct-mapped cache
// and its backing-store model.
package dm_cache_pkg;

    localparam int LINE_W     = 128;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int WORDS      = LINE_W / WORD_W;
    localparam int OFFSET_MSB = 3;
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = 4;
    localparam int TAGMSB     = 31;
    localparam int TAGLSB     = 14;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    // Power-up content: each word holds its own word address.
    function automatic logic [LINE_W-1:0] init_line(int idx);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < WORDS; k++) begin
            l[k*WORD_W +: WORD_W] = WORD_W'(idx * WORDS + k);
        end
        return l;
    endfunction

endpackage

// File: rtl/dm_main_mem_array.sv
// Line storage for the main-memory model: combinational read port,
// synchronous write port, contents survive reset.
module dm_main_mem_array
    import dm_cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [LINE_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [LINE_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_W-1:0] rd_lines [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_line
        localparam logic [DEPTH_LOG2-1:0] IDX = DEPTH_LOG2'(i);
        // Declaration value gives the power-up image without a reset.
        logic [LINE_W-1:0] line_q = init_line(i);

        always_ff @(posedge clk) begin
            if (we && waddr == IDX) begin
                line_q <= wdata;
            end
        end

        assign rd_lines[i] = line_q;
    end

    assign rdata = rd_lines[raddr];

endmodule

// File: rtl/dm_main_mem.sv
// Fixed-latency line store answering cache refills and write-backs
// with a single-cycle completion pulse.
module dm_main_mem
    import dm_cache_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic              mem_data_ready,
    output logic [LINE_W-1:0] mem_data_data,
    output logic              mem_busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam int         IMSB   = DEPTH_LOG2 + INDEX_LSB - 1;

    mem_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [LINE_W-1:0]     data_q;
    logic                  accept;
    logic                  we;
    logic [LINE_W-1:0]     rd_line;
    logic                  unused_addr;

    assign unused_addr = ^{mem_req_addr[ADDR_W-1:IMSB+1],
                           mem_req_addr[OFFSET_MSB:OFFSET_LSB]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: accept = mem_req_valid;
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                accept  = mem_req_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cnt_d   = LAT_M1;
            state_d = (LATENCY == 1) ? RESP : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rw_q   <= mem_req_rw;
                idx_q  <= mem_req_addr[IMSB:INDEX_LSB];
                data_q <= mem_req_data;
            end
        end
    end

    // Reset on the RESP-ending edge must suppress the commit.
    assign we = (state_q == RESP) && rw_q && !rst;

    dm_main_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(idx_q),
        .wdata(data_q),
        .raddr(idx_q),
        .rdata(rd_line)
    );

    assign mem_data_ready = (state_q == RESP);
    assign mem_data_data  = (state_q == RESP && !rw_q) ? rd_line : '0;
    assign mem_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dm_main_mem.sv
// Directed and randomized checks of dm_main_mem against a line-array
// reference model, at LATENCY=4 and LATENCY=1.
module tb_dm_main_mem;

    localparam int L4 = 4;

    logic         clk = 1'b0;
    logic         rst4, valid4, rw4, rdy4, busy4;
    logic [31:0]  addr4;
    logic [127:0] wd4, rd4;
    logic         rst1, valid1, rw1, rdy1, busy1;
    logic [31:0]  addr1;
    logic [127:0] wd1, rd1;

    int checks = 0;
    int errors = 0;

    logic [127:0] mdl4 [4096];
    logic [127:0] mdl1 [64];

    always #5 clk = ~clk;

    dm_main_mem #(.LATENCY(4), .DEPTH_LOG2(12)) u4 (
        .clk(clk), .rst(rst4),
        .mem_req_valid(valid4), .mem_req_rw(rw4),
        .mem_req_addr(addr4), .mem_req_data(wd4),
        .mem_data_ready(rdy4), .mem_data_data(rd4),
        .mem_busy(busy4)
    );

    dm_main_mem #(.LATENCY(1), .DEPTH_LOG2(6)) u1 (
        .clk(clk), .rst(rst1),
        .mem_req_valid(valid1), .mem_req_rw(rw1),
        .mem_req_addr(addr1), .mem_req_data(wd1),
        .mem_data_ready(rdy1), .mem_data_data(rd1),
        .mem_busy(busy1)
    );

    function automatic logic [127:0] init_ln(int i);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'(i * 4 + k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue at the current (IDLE or RESP) cycle; returns in its RESP cycle.
    task automatic txn4(input bit rw, input logic [31:0] a,
                        input logic [127:0] d, input string tag);
        int idx;
        logic [127:0] exp;
        idx = int'(a[15:4]);
        valid4 = 1'b1; rw4 = rw; addr4 = a; wd4 = d;
        for (int c = 1; c <= L4; c++) begin
            step();
            if (c < L4) begin
                valid4 = 1'($urandom_range(0, 1));
                rw4    = 1'($urandom_range(0, 1));
                addr4  = $urandom;
                wd4    = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                valid4 = 1'b0;
            end
            chk({tag, "/busy"}, busy4, 1);
            chk({tag, "/rdy"}, rdy4, (c == L4) ? 1 : 0);
            if (c < L4) chk({tag, "/data_idle"}, rd4, 0);
        end
        exp = rw ? 128'h0 : mdl4[idx];
        chk({tag, "/data"}, rd4, exp);
        if (rw) mdl4[idx] = d;
    endtask

    task automatic idle4(input string tag);
        valid4 = 1'b0;
        step();
        chk({tag, "/idle_busy"}, busy4, 0);
        chk({tag, "/idle_rdy"}, rdy4, 0);
        chk({tag, "/idle_data"}, rd4, 0);
    endtask

    initial begin
        logic [31:0]  a;
        logic [127:0] d;
        bit           rw;
        bit           prw  [21];
        int           pidx [21];
        logic [127:0] pdat [21];

        for (int i = 0; i < 4096; i++) mdl4[i] = init_ln(i);
        for (int i = 0; i < 64; i++) mdl1[i] = init_ln(i);

        rst4 = 1'b1; valid4 = 1'b0; rw4 = 1'b0; addr4 = '0; wd4 = '0;
        rst1 = 1'b1; valid1 = 1'b0; rw1 = 1'b0; addr1 = '0; wd1 = '0;
        step();
        step();
        chk("reset/busy", busy4, 0);
        chk("reset/rdy", rdy4, 0);
        chk("reset/data", rd4, 0);
        chk("reset/busy1", busy1, 0);
        rst4 = 1'b0; rst1 = 1'b0;
        step();

        txn4(1'b0, 32'h0000_0010, '0, "rd_line1");
        chk("rd_line1/const", rd4, 128'h00000007_00000006_00000005_00000004);
        idle4("rd_line1");

        d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        txn4(1'b1, 32'h0000_0120, d, "wr_120");
        idle4("wr_120");
        txn4(1'b0, 32'h0000_0120, '0, "rd_120");
        chk("rd_120/const", rd4, d);
        idle4("rd_120");
        txn4(1'b0, 32'h0001_0120, '0, "rd_alias");
        chk("rd_alias/const", rd4, d);
        idle4("rd_alias");

        txn4(1'b1, 32'h0000_0050, {4{32'h5A5A_0005}}, "b2b_wr5");
        txn4(1'b0, 32'h0000_0090, '0, "b2b_rd9");
        chk("b2b_rd9/const", rd4, 128'h00000027_00000026_00000025_00000024);
        txn4(1'b0, 32'h0000_0050, '0, "b2b_rd5");
        chk("b2b_rd5/const", rd4, {4{32'h5A5A_0005}});
        idle4("b2b_rd5");

        valid4 = 1'b1; rw4 = 1'b1; addr4 = 32'h0000_0300; wd4 = {4{32'h1111_2222}};
        step();
        valid4 = 1'b0;
        step();
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("rstmid/busy", busy4, 0);
            chk("rstmid/rdy", rdy4, 0);
            step();
        end
        txn4(1'b0, 32'h0000_0300, '0, "rstmid_rd");
        idle4("rstmid_rd");

        valid4 = 1'b1; rw4 = 1'b1; addr4 = 32'h0000_0310; wd4 = {4{32'h3333_4444}};
        for (int c = 1; c <= L4; c++) begin
            step();
            valid4 = 1'b0;
        end
        chk("rstresp/rdy", rdy4, 1);
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        chk("rstresp/busy", busy4, 0);
        chk("rstresp/rdy0", rdy4, 0);
        step();
        txn4(1'b0, 32'h0000_0310, '0, "rstresp_rd");
        idle4("rstresp_rd");

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            a[15:8] = '0;
            d = {$urandom, $urandom, $urandom, $urandom};
            txn4(1'($urandom_range(0, 1)), a, d, "rand4");
            if ($urandom_range(0, 1) == 1) idle4("rand4");
        end
        idle4("rand4_end");

        for (int c = 0; c <= 20; c++) begin
            if (c >= 1) begin
                chk("lat1/rdy", rdy1, 1);
                chk("lat1/busy", busy1, 1);
                chk("lat1/data", rd1, prw[c-1] ? 128'h0 : mdl1[pidx[c-1]]);
                if (prw[c-1]) mdl1[pidx[c-1]] = pdat[c-1];
            end else begin
                chk("lat1/rdy0", rdy1, 0);
            end
            if (c < 20) begin
                rw = 1'($urandom_range(0, 1));
                a = $urandom;
                a[9:7] = '0;
                d = {$urandom, $urandom, $urandom, $urandom};
                prw[c] = rw; pidx[c] = int'(a[9:4]); pdat[c] = d;
                valid1 = 1'b1; rw1 = rw; addr1 = a; wd1 = d;
            end else begin
                valid1 = 1'b0;
            end
            step();
        end
        chk("lat1/end_rdy", rdy1, 0);
        chk("lat1/end_busy", busy1, 0);
        for (int i = 0; i < 8; i++) begin
            valid1 = 1'b1; rw1 = 1'b0; addr1 = 32'(i << 4);
            step();
            valid1 = 1'b0;
            chk("lat1/final_rd", rd1, mdl1[i]);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_main_mem.md
# dm_main_mem

Backing-store model and controller that sits directly downstream of the direct-mapped cache controller (`dm_cache_fsm`). It answers the cache's 128-bit line refill (read) and write-back (write) requests with a fixed, parameterised latency and a one-cycle `mem_data_ready` pulse. It is used in simulation and for the system-level bring-up of the cache.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from request acceptance to the `mem_data_ready` pulse. Legal range is 1..15.
- `DEPTH_LOG2`, default 12: number of 128-bit lines is 2^DEPTH_LOG2. The line index is `mem_req_addr[DEPTH_LOG2+3:4]`; higher address bits are ignored (aliasing).

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mem_req_valid`, input, 1: request present.
- `mem_req_rw`, input, 1: 1 = write line, 0 = read line.
- `mem_req_addr`, input, 32: byte address. Bits [3:0] are ignored.
- `mem_req_data`, input, 128: line to write.
- `mem_data_ready`, output, 1: one-cycle completion pulse for reads and writes.
- `mem_data_data`, output, 128: read line. Valid only while `mem_data_ready` is high on a read; 0 otherwise.
- `mem_busy`, output, 1: high whenever the FSM is not IDLE.

## Operation
- The FSM has three states: IDLE, BUSY and RESP. All outputs reset to 0 and the state resets to IDLE.
- IDLE:
  - When `mem_req_valid`=1, capture rw, line index and write data into holding registers and load the down-counter with LATENCY-1.
  - Next state is RESP if LATENCY=1, otherwise BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - Decrement the counter each cycle. Move to RESP in the cycle after the counter reaches 1.
  - `mem_req_*` inputs are ignored; no second request is queued.
- RESP:
  - Drive `mem_data_ready`=1 for exactly this cycle.
  - On a read, `mem_data_data` = array[captured index].
  - On a write, the array line is written at the rising edge that ends RESP.
  - Back-to-back: if `mem_req_valid`=1 in RESP, that request is captured exactly as in IDLE. This supports the write-back followed by refill sequence.
  - Otherwise next state is IDLE.
- Array contents are not affected by `rst`. Initial contents: word k of line i = {i, k[1:0]} zero-extended to 32 bits, which is the word address of that location.
- Reset mid-operation: abandon the request. A pending write is not committed unless reset coincides with the RESP-ending edge, in which case reset wins and there is no write. No ready pulse is produced.
- Requester contract: `mem_req_valid` must be low in every IDLE/RESP cycle in which no new request is intended. Addresses presented while BUSY are don't-care.

## Timing
- A request accepted in cycle 0 gets `mem_data_ready` in cycle LATENCY. The next request can be accepted in cycle LATENCY, giving a throughput of one line per LATENCY cycles.
- Read data comes combinationally from the array during RESP. Read-during-write to the same line in the same RESP cycle cannot occur, because RESP serves one request only.
- A read accepted in the RESP cycle of a write to the same line returns the newly written data.
- `mem_busy` is registered-state-derived: high from cycle 1 through cycle LATENCY inclusive.

## Structure
- Shared package `dm_cache_pkg` holds:
  - `LINE_W`=128, `ADDR_W`=32, `TAGMSB`/`TAGLSB`, the offset field [3:0] and the index LSB = 4.
  - The `mem_state_t` enum {IDLE, BUSY, RESP}.
  - The tag field constants, so the cache controller and this block agree on address slicing.
- Sub-module `dm_main_mem_array`: 2^DEPTH_LOG2 x 128 storage with an init loop, one combinational read port and one synchronous write port with enable. The FSM, counter and holding registers stay in `dm_main_mem`.

## Test plan
- **Reset, then read.** Reset, LATENCY=4, read addr 0x0000_0010 at cycle 0. Expect `mem_data_ready` only in cycle 4, `mem_data_data`=0x00000007_00000006_00000005_00000004, and `mem_busy` high in cycles 1-4.
- **Write then read.** Write 0xDEADBEEF_… pattern to 0x0000_0120, then read 0x0000_0120. Expect two ready pulses and the read returning the written line. A read of 0x0001_0120 returns the same line (alias, DEPTH_LOG2=12).
- **Back-to-back.** Write to line 5, with a read of line 9 asserted in the write's RESP cycle. Expect the read accepted with no IDLE gap, its ready exactly LATENCY cycles later, and line 9 holding its initial content.
- **Reset mid-op.** Start a write, assert `rst` in cycle 2. Expect no ready pulse, return to IDLE, and a subsequent read of that line returning initial content. Repeat with `rst` in the RESP cycle: still no commit.
- **Minimum latency.** LATENCY=1: request in cycle 0 gives ready in cycle 1. Twenty consecutive back-to-back requests give one ready per cycle from cycle 1.
- **Ignored input.** `mem_req_valid` toggling while BUSY produces no extra responses and does not change the captured address or data.
